// File: rtl/inst_encoder.sv
`default_nettype none
// ============================================================================
//  Module   : inst_encoder
//  Purpose  : Sequential MIPS instruction encoder and program loader. Takes
//             field-level instruction requests over a valid/ready handshake,
//             assembles 32-bit words (R-type, lw, sw, beq, addi, j) and writes
//             them into instruction memory from word address 0 upward.
//  Ports    : clk, rst          - clock, synchronous active-high reset
//             restart           - rewind load pointer to 0, clear full
//             in_valid/in_ready - request handshake (in_ready combinational)
//             kind, rs, rt, rd, shamt, funct, imm, target - request fields
//             imem_we/addr/wdata - registered instruction-memory write port
//             count             - words accepted since reset/restart
//             full              - count == 2^ADDR_W
//             err               - sticky illegal-kind flag (cleared by rst)
//  Revision : 1.0  initial release
// ============================================================================
module inst_encoder #(
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              restart,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [2:0]        kind,
    input  logic [4:0]        rs,
    input  logic [4:0]        rt,
    input  logic [4:0]        rd,
    input  logic [4:0]        shamt,
    input  logic [5:0]        funct,
    input  logic [15:0]       imm,
    input  logic [25:0]       target,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       imem_wdata,
    output logic [ADDR_W:0]   count,
    output logic              full,
    output logic              err
);

    localparam logic [0:0]      c_st_load = 1'b0;
    localparam logic [0:0]      c_st_full = 1'b1;
    // Value of count just before the final word is accepted.
    localparam logic [ADDR_W:0] c_last    = {1'b0, {ADDR_W{1'b1}}};
    localparam logic [ADDR_W:0] c_one     = {{ADDR_W{1'b0}}, 1'b1};

    logic [0:0]        r_state;
    logic [ADDR_W:0]   r_count;
    logic              r_we;
    logic [ADDR_W-1:0] r_addr;
    logic [31:0]       r_wdata;
    logic              r_err;

    logic              w_ready;
    logic              w_accept;
    logic              w_legal;
    logic [31:0]       w_enc;

    // restart blocks acceptance in the same cycle it is asserted.
    assign w_ready  = (r_state == c_st_load) && !restart;
    assign w_accept = in_valid && w_ready;

    // Field assembly; fields not used by a class are simply not selected.
    always_comb begin
        w_legal = 1'b1;
        w_enc   = 32'h0000_0000;
        case (kind)
            3'd0:    w_enc = {6'b000000, rs, rt, rd, shamt, funct};
            3'd1:    w_enc = {6'b100011, rs, rt, imm};
            3'd2:    w_enc = {6'b101011, rs, rt, imm};
            3'd3:    w_enc = {6'b000100, rs, rt, imm};
            3'd4:    w_enc = {6'b001000, rs, rt, imm};
            3'd5:    w_enc = {6'b000010, target};
            default: w_legal = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_st_load;
            r_count <= '0;
            r_we    <= 1'b0;
            r_addr  <= '0;
            r_wdata <= 32'h0000_0000;
            r_err   <= 1'b0;
        end else begin
            // Write strobe is a single-cycle pulse; a pulse already registered
            // before a restart is left to complete.
            r_we <= 1'b0;
            if (restart) begin
                r_state <= c_st_load;
                r_count <= '0;
            end else if (w_accept) begin
                if (w_legal) begin
                    r_we    <= 1'b1;
                    r_addr  <= r_count[ADDR_W-1:0];
                    r_wdata <= w_enc;
                    r_count <= r_count + c_one;
                    if (r_count == c_last) begin
                        r_state <= c_st_full;
                    end
                end else begin
                    // Illegal kind is consumed without a write.
                    r_err <= 1'b1;
                end
            end
        end
    end

    assign in_ready   = w_ready;
    assign imem_we    = r_we;
    assign imem_addr  = r_addr;
    assign imem_wdata = r_wdata;
    assign count      = r_count;
    assign full       = (r_state == c_st_full);
    assign err        = r_err;

endmodule
`default_nettype wire

// File: doc/inst_encoder.md
# inst_encoder

Sequential MIPS instruction encoder and program loader, the encoding counterpart of the control decoder. It accepts field-level instruction requests over a valid/ready handshake and assembles 32-bit words for the six supported classes: R-type, lw, sw, beq, addi and j. It writes those words sequentially into instruction memory from address 0. It sits between the test/boot sequencer and the instruction RAM, filling program memory before the datapath runs.

## Interface
- ADDR_W, default 8: instruction-memory word-address width; depth = 2^ADDR_W words.
- clk  in  1  single clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- restart  in  1  synchronous; rewinds the load pointer to 0 and clears `full`.
- in_valid  in  1  request valid.
- in_ready  out  1  combinational: !full && !restart.
- kind  in  3  instruction class:
  - 0 = R-type, 1 = lw, 2 = sw, 3 = beq, 4 = addi, 5 = j.
  - 6 and 7 are illegal.
- rs, rt, rd, shamt  in  5 each  register and shift fields.
- funct  in  6  R-type function field.
- imm  in  16  immediate or branch offset.
- target  in  26  jump target field.
- imem_we  out  1  one-cycle write strobe.
- imem_addr  out  ADDR_W  write word address.
- imem_wdata  out  32  encoded instruction.
- count  out  ADDR_W+1  number of words accepted for writing since reset or restart.
- full  out  1  count == 2^ADDR_W.
- err  out  1  sticky illegal-kind flag.

## Operation
- FSM states: LOAD (in_ready follows !restart) and FULL (in_ready = 0).
  - LOAD→FULL on the edge at which count reaches 2^ADDR_W.
  - FULL→LOAD only on restart or rst.
- Acceptance = in_valid && in_ready at a rising edge. Inputs are sampled only at acceptance.
- Encoding (opcode in bits 31:26):
  - R-type: {6'b000000, rs, rt, rd, shamt, funct}
  - lw: {6'b100011, rs, rt, imm}
  - sw: {6'b101011, rs, rt, imm}
  - beq: {6'b000100, rs, rt, imm}
  - addi: {6'b001000, rs, rt, imm}
  - j: {6'b000010, target}
  - Unused fields for a class are ignored.
- Legal acceptance:
  - Output register loads imem_addr = count[ADDR_W-1:0] and imem_wdata = the encoded word.
  - imem_we = 1 for the following cycle.
  - count increments by 1.
- Illegal kind (6 or 7):
  - The request is consumed (handshake completes).
  - No write; imem_we stays 0; count unchanged.
  - err is set and stays 1 until rst. restart does not clear it.
- imem_addr and imem_wdata hold their last values while imem_we = 0.
- No wrap-around: the pointer never passes 2^ADDR_W−1. FULL blocks further requests.
- restart:
  - count = 0, full = 0, state LOAD.
  - A write already registered still completes (imem_we pulse is not cancelled).
  - No acceptance occurs in a restart cycle.
- Reset values: imem_we = 0, imem_addr = 0, imem_wdata = 0, count = 0, full = 0, err = 0, state LOAD.
- rst mid-stream drops any registered write: imem_we = 0 in the cycle after rst.

## Timing
- Latency: acceptance at edge N → imem_we high in cycle N to N+1, with address and data valid in that same cycle.
- Throughput: one request per cycle, back to back, with no bubbles.
- count and full update at the acceptance edge. in_ready falls combinationally in the cycle after the final acceptance.
- in_valid may be held while in_ready = 0. The request stays pending and is accepted at the first edge with in_ready = 1.
- rst has priority over restart; restart has priority over acceptance.

## Test plan
- Encode one of each class into consecutive addresses 0–5:
  - add $3,$1,$2 (kind 0, rs 1, rt 2, rd 3, funct 0x20) → 0x00221820
  - lw $2,4($0) → 0x8C020004
  - sw $2,8($0) → 0xAC020008
  - beq $1,$2,imm 0xFFFF → 0x1022FFFF
  - addi $1,$0,5 → 0x20010005
  - j target 0x10 → 0x08000010
  - Expect imem_we pulses one cycle after each acceptance.
- ADDR_W = 2, five back-to-back valid requests:
  - Writes occur at addresses 0, 1, 2, 3.
  - count = 4, full = 1, in_ready = 0.
  - The fifth request is held and never written.
- kind = 6 between two legal requests:
  - No write for the illegal request; err = 1 permanently.
  - The legal requests land at addresses 0 and 1, and count = 2.
- From the full state, pulse restart with in_valid = 1:
  - No acceptance in the restart cycle; count = 0 and full = 0.
  - The next request is written to address 0. err survives.
- Assert rst in the cycle after an acceptance:
  - imem_we = 0 in the cycle after rst.
  - All outputs return to 0, including err, and count = 0.
